// File: rtl/sdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdm_pkg
// Description : Shared constants, state encodings and step sign-extension
//               helper for the SDM interpolating upsampler.
// Revision    : 1.0 - initial release
// ============================================================================
package sdm_pkg;

    localparam int c_N_DEFAULT = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Sign-extends the low 'width' bits of value to 64 bits; callers cast
    // the result down to their accumulator width.
    function automatic logic [63:0] sext_step(input logic [63:0] value, input int width);
        logic [63:0] w_mask;
        logic [63:0] w_sign;
        w_mask = ~64'd0 << width;
        w_sign = (value >> (width - 1)) & 64'd1;
        if (w_sign != 64'd0) begin
            return value | w_mask;
        end
        return value & ~w_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdm_interp_upsampler.sv
`default_nettype none
// ============================================================================
// Module      : sdm_interp_upsampler
// Description : Valid/ready fed upsampler producing one word per clk for the
//               SDM DAC core. INTERP_LINEAR_EN selects linear interpolation;
//               when undefined, a zero-order hold is built instead.
// Revision    : 1.0 - initial release
// ============================================================================
module sdm_interp_upsampler
    import sdm_pkg::*;
#(
    parameter int N     = c_N_DEFAULT,
    parameter int LOG2R = 1
) (
    input  logic         clk,
    input  logic         areset,
    input  logic [N-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [N-1:0] dout,
    output logic         underrun
);

    localparam int c_R      = 1 << LOG2R;
    localparam int c_ACC_W  = N + LOG2R;
    localparam int c_STEP_W = N + 1;
    localparam int c_PH_W   = (LOG2R > 0) ? LOG2R : 1;
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(c_R - 1);

    logic [1:0]         r_state;
    logic [c_PH_W-1:0]  r_phase;
    logic [N-1:0]       r_prev;
    logic [N-1:0]       r_cur;
    logic [c_ACC_W-1:0] r_acc;
    logic               r_underrun;

    logic               w_ready;
    logic               w_xfer;
    logic [N-1:0]       w_dout;
    logic [c_ACC_W-1:0] w_acc_run;
    logic [c_ACC_W-1:0] w_acc_load;
    logic               w_unused_prev;

`ifdef INTERP_LINEAR_EN
    logic [c_STEP_W-1:0] r_step;
    logic [c_STEP_W-1:0] w_step_load;

    assign w_acc_run   = r_acc + c_ACC_W'(sext_step(64'(r_step), c_STEP_W));
    assign w_acc_load  = c_ACC_W'(r_cur) << LOG2R;
    assign w_step_load = c_STEP_W'(s_data) - c_STEP_W'(r_cur);
`else
    assign w_acc_run   = r_acc;
    assign w_acc_load  = c_ACC_W'(s_data) << LOG2R;
`endif

    // prev is architectural state only; dout is rebuilt from acc.
    assign w_unused_prev = ^r_prev;

    assign w_xfer   = s_valid & w_ready;
    assign s_ready  = w_ready & ~areset;
    assign dout     = w_dout;
    assign underrun = r_underrun;

    always_comb begin
        w_ready = 1'b0;
        w_dout  = '0;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
            ST_PRIME: w_ready = 1'b1;
            ST_RUN: begin
                w_ready = (r_phase == c_PH_LAST);
                w_dout  = r_acc[c_ACC_W-1:LOG2R];
            end
            default: begin
                w_ready = 1'b0;
                w_dout  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_prev     <= '0;
            r_cur      <= '0;
            r_acc      <= '0;
            r_underrun <= 1'b0;
`ifdef INTERP_LINEAR_EN
            r_step     <= '0;
`endif
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_cur   <= s_data;
                        r_state <= ST_PRIME;
                    end
                end
                ST_PRIME, ST_RUN: begin
                    if (r_state == ST_RUN && r_phase != c_PH_LAST) begin
                        r_acc   <= w_acc_run;
                        r_phase <= r_phase + c_PH_W'(1);
                    end else if (w_xfer) begin
                        r_prev  <= r_cur;
                        r_cur   <= s_data;
                        r_acc   <= w_acc_load;
                        r_phase <= '0;
                        r_state <= ST_RUN;
`ifdef INTERP_LINEAR_EN
                        r_step  <= w_step_load;
`endif
                    end else if (r_state == ST_RUN) begin
                        // Starved at a boundary: hold cur flat and flag it.
                        r_prev     <= r_cur;
                        r_acc      <= c_ACC_W'(r_cur) << LOG2R;
                        r_phase    <= '0;
                        r_underrun <= 1'b1;
`ifdef INTERP_LINEAR_EN
                        r_step     <= '0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdm_interp_upsampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdm_interp_upsampler
// Description : Directed self-checking bench for sdm_interp_upsampler,
//               LOG2R=1 and LOG2R=2 instances; INTERP_LINEAR_EN aware.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdm_interp_upsampler;

    logic        clk = 1'b0;
    logic        areset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] dout;
    logic        underrun;

    logic        areset2;
    logic [15:0] s_data2;
    logic        s_valid2;
    logic        s_ready2;
    logic [15:0] dout2;
    logic        underrun2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdm_interp_upsampler #(.N(16), .LOG2R(1)) dut (
        .clk      (clk),
        .areset   (areset),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .dout     (dout),
        .underrun (underrun)
    );

    sdm_interp_upsampler #(.N(16), .LOG2R(2)) dut2 (
        .clk      (clk),
        .areset   (areset2),
        .s_data   (s_data2),
        .s_valid  (s_valid2),
        .s_ready  (s_ready2),
        .dout     (dout2),
        .underrun (underrun2)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clk on the R=2 instance; exp_lin / exp_zoh are the interpolating
    // and zero-order-hold dout expectations respectively.
    task automatic step1(input string tag, input logic v, input logic [15:0] d,
                         input logic [15:0] exp_lin, input logic [15:0] exp_zoh,
                         input logic exp_rdy, input logic exp_ur);
        logic [15:0] exp_dout;
`ifdef INTERP_LINEAR_EN
        exp_dout = exp_lin;
`else
        exp_dout = exp_zoh;
`endif
        s_valid = v;
        s_data  = d;
        tick();
        check({tag, " dout"}, dout, exp_dout);
        check({tag, " s_ready"}, 16'(s_ready), 16'(exp_rdy));
        check({tag, " underrun"}, 16'(underrun), 16'(exp_ur));
    endtask

    task automatic step2(input string tag, input logic v, input logic [15:0] d,
                         input logic [15:0] exp_lin, input logic [15:0] exp_zoh,
                         input logic exp_rdy);
        logic [15:0] exp_dout;
`ifdef INTERP_LINEAR_EN
        exp_dout = exp_lin;
`else
        exp_dout = exp_zoh;
`endif
        s_valid2 = v;
        s_data2  = d;
        tick();
        check({tag, " dout"}, dout2, exp_dout);
        check({tag, " s_ready"}, 16'(s_ready2), 16'(exp_rdy));
        check({tag, " underrun"}, 16'(underrun2), 16'd0);
    endtask

    initial begin
        areset   = 1'b1;
        s_valid  = 1'b0;
        s_data   = 16'h0000;
        areset2  = 1'b1;
        s_valid2 = 1'b0;
        s_data2  = 16'h0000;
        repeat (3) tick();

        check("rst dout", dout, 16'h0000);
        check("rst s_ready", 16'(s_ready), 16'd0);
        check("rst underrun", 16'(underrun), 16'd0);

        areset = 1'b0;
        #1;
        check("rel s_ready", 16'(s_ready), 16'd1);

        // Ramp, then a dropped boundary after 0x2000
        step1("E1",  1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        step1("E2",  1'b1, 16'h1000, 16'h0000, 16'h1000, 1'b0, 1'b0);
        step1("E3",  1'b1, 16'h3000, 16'h0800, 16'h1000, 1'b1, 1'b0);
        step1("E4",  1'b1, 16'h3000, 16'h1000, 16'h3000, 1'b0, 1'b0);
        step1("E5",  1'b1, 16'h2000, 16'h2000, 16'h3000, 1'b1, 1'b0);
        step1("E6",  1'b1, 16'h2000, 16'h3000, 16'h2000, 1'b0, 1'b0);
        step1("E7",  1'b0, 16'h0000, 16'h2800, 16'h2000, 1'b1, 1'b0);
        step1("E8",  1'b0, 16'h0000, 16'h2000, 16'h2000, 1'b0, 1'b1);
        step1("E9",  1'b0, 16'h0000, 16'h2000, 16'h2000, 1'b1, 1'b0);
        step1("E10", 1'b1, 16'h2800, 16'h2000, 16'h2800, 1'b0, 1'b0);
        step1("E11", 1'b0, 16'h0000, 16'h2400, 16'h2800, 1'b1, 1'b0);

        // Reset asserted mid-RUN while a sample is offered
        areset  = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'hFFFF;
        #1;
        check("midrst s_ready comb", 16'(s_ready), 16'd0);
        tick();
        check("midrst dout", dout, 16'h0000);
        check("midrst s_ready", 16'(s_ready), 16'd0);
        check("midrst underrun", 16'(underrun), 16'd0);
        areset  = 1'b0;
        s_valid = 1'b0;
        #1;
        check("midrst rel s_ready", 16'(s_ready), 16'd1);

        // Full-scale swings, then 0x1234 -> 0x5678
        step1("F1",  1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0);
        step1("F2",  1'b1, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        step1("F3",  1'b1, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
        step1("F4",  1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        step1("F5",  1'b0, 16'h0000, 16'h7FFF, 16'hFFFF, 1'b1, 1'b0);
        step1("F6",  1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        step1("F7",  1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        step1("F8",  1'b1, 16'h1234, 16'hFFFF, 16'h1234, 1'b0, 1'b0);
        step1("F9",  1'b1, 16'h5678, 16'h8919, 16'h1234, 1'b1, 1'b0);
        step1("F10", 1'b1, 16'h5678, 16'h1234, 16'h5678, 1'b0, 1'b0);
        step1("F11", 1'b0, 16'h0000, 16'h3456, 16'h5678, 1'b1, 1'b0);
        step1("F12", 1'b0, 16'h0000, 16'h5678, 16'h5678, 1'b0, 1'b1);

        // R=4 instance
        areset2 = 1'b0;
        #1;
        check("G0 s_ready", 16'(s_ready2), 16'd1);
        step2("G1", 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        step2("G2", 1'b1, 16'h0100, 16'h0000, 16'h0100, 1'b0);
        step2("G3", 1'b1, 16'h0200, 16'h0040, 16'h0100, 1'b0);
        step2("G4", 1'b1, 16'h0200, 16'h0080, 16'h0100, 1'b0);
        step2("G5", 1'b1, 16'h0200, 16'h00C0, 16'h0100, 1'b1);
        step2("G6", 1'b1, 16'h0200, 16'h0100, 16'h0200, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
